// File: rtl/icache_ctrl_if.sv
// ----------------------------------------------------------------------------
// icache_ctrl_if
//   Bundles the fetch-side and refill-memory-side signals of icache_ctrl.
//   slave  : the cache controller (consumes pc/flush/mem_ack/mem_rdata)
//   master : its environment (PC register + instruction memory)
// Signals
//   pc        fetch address (pc[1:0] ignored)
//   flush     invalidate all lines
//   ihit      pc hits a valid line this cycle
//   instr     instruction at pc when ihit, else 0
//   mem_req   refill word request
//   mem_addr  word address of the refill request
//   mem_ack   memory returns mem_rdata this cycle
//   mem_rdata refill data
// ----------------------------------------------------------------------------
interface icache_ctrl_if;
    logic [31:0] pc;
    logic        flush;
    logic        ihit;
    logic [31:0] instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output pc, flush, mem_ack, mem_rdata,
        input  ihit, instr, mem_req, mem_addr
    );

    modport slave (
        input  pc, flush, mem_ack, mem_rdata,
        output ihit, instr, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_ctrl.sv
// ----------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped, read-only instruction cache with a line refill controller.
//   A hit returns the instruction in the same cycle; a miss stalls fetch
//   (ihit=0) while one full line is fetched word by word over a req/ack
//   handshake, after which the line is validated and the access hits.
// Ports
//   clk   clock, all state updates on posedge
//   rst   asynchronous reset, active-high
//   bus   icache_ctrl_if.slave (pc, flush, ihit, instr, mem_* refill port)
//   hit_cnt/miss_cnt (only with ICACHE_STATS_EN defined) hit/miss counters
// Configuration
//   ICACHE_STATS_EN : when defined, adds the hit_cnt and miss_cnt outputs.
// ----------------------------------------------------------------------------
module icache_ctrl #(
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    icache_ctrl_if.slave       bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = WOFF_W + 2;
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StRefill = 1'b1;

    localparam logic [WOFF_W-1:0] LastWord = WOFF_W'(LINE_WORDS - 1);

    // Storage
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];

    // Controller state
    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [TAG_W-1:0]  rtag_q, rtag_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic              flushed_q, flushed_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;

    // PC decode
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  pc_idx;
    logic [WOFF_W-1:0] pc_woff;
    logic              unused_pc;

    assign pc_tag    = bus.pc[31 -: TAG_W];
    assign pc_idx    = bus.pc[OFF_W +: IDX_W];
    assign pc_woff   = bus.pc[2 +: WOFF_W];
    assign unused_pc = ^bus.pc[1:0];

    logic hit;
    logic fill_we;
    logic last_ack;
    logic miss_start;

    always_comb begin
        hit = (state_q == StIdle) && valid_q[pc_idx] &&
              (tag_mem[pc_idx] == pc_tag) && !bus.flush;
    end

    assign bus.ihit     = hit;
    assign bus.instr    = hit ? data_mem[{pc_idx, pc_woff}] : 32'h0;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;

    // mem_req is high for the whole refill, so a REFILL-state ack is a real transfer.
    assign fill_we    = (state_q == StRefill) && bus.mem_ack;
    assign last_ack   = fill_we && (cnt_q == LastWord);
    assign miss_start = (state_q == StIdle) && !hit;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ridx_d     = ridx_q;
        rtag_d     = rtag_q;
        cnt_d      = cnt_q;
        flushed_d  = flushed_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        case (state_q)
            StIdle: begin
                if (miss_start) begin
                    state_d    = StRefill;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {bus.pc[31:OFF_W], {OFF_W{1'b0}}};
                    ridx_d     = pc_idx;
                    rtag_d     = pc_tag;
                    cnt_d      = '0;
                    flushed_d  = 1'b0;
                end
            end
            StRefill: begin
                // A flush seen anywhere in the burst poisons the line being filled.
                if (bus.flush) begin
                    flushed_d = 1'b1;
                end
                if (fill_we) begin
                    if (last_ack) begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = mem_addr_q + 32'd4;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase

        if (bus.flush) begin
            valid_d = '0;
        end
        if (last_ack && !flushed_q && !bus.flush) begin
            valid_d[ridx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            ridx_q     <= '0;
            rtag_q     <= '0;
            cnt_q      <= '0;
            flushed_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            ridx_q     <= ridx_d;
            rtag_q     <= rtag_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Arrays carry no reset: contents are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{ridx_q, cnt_q}] <= bus.mem_rdata;
        end
        if (last_ack) begin
            tag_mem[ridx_q] <= rtag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_start) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
    localparam int NL = 64;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_ctrl_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_ctrl #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit run_chk = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_refill;
    logic [31:0] m_base;
    int          m_k;
    bit          m_flushed;
    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL][LW];
    int unsigned m_hits, m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / (4 * LW)) % NL);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * LW * NL);
    endfunction

    function automatic bit exp_hit();
        int li;
        li = line_of(bus.pc);
        return !m_refill && m_valid[li] && (m_tag[li] == tag_of(bus.pc)) && !bus.flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_refill  = 0;
            m_k       = 0;
            m_flushed = 0;
            m_hits    = 0;
            m_misses  = 0;
            for (int i = 0; i < NL; i++) m_valid[i] = 0;
        end else if (!m_refill) begin
            if (exp_hit()) begin
                m_hits++;
            end else begin
                m_refill  = 1;
                m_base    = bus.pc & ~32'(4 * LW - 1);
                m_k       = 0;
                m_flushed = 0;
                m_misses++;
            end
            if (bus.flush) for (int i = 0; i < NL; i++) m_valid[i] = 0;
        end else begin
            if (bus.flush) begin
                m_flushed = 1;
                for (int i = 0; i < NL; i++) m_valid[i] = 0;
            end
            if (bus.mem_ack) begin
                m_data[line_of(m_base)][m_k] = mem_word(m_base + 32'(4 * m_k));
                if (m_k == LW - 1) begin
                    m_refill = 0;
                    m_tag[line_of(m_base)] = tag_of(m_base);
                    if (!m_flushed) m_valid[line_of(m_base)] = 1;
                end else begin
                    m_k++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (!rst && run_chk) begin
            bit eh;
            eh = exp_hit();
            chk("ihit", {31'b0, bus.ihit}, {31'b0, eh});
            chk("instr", bus.instr,
                eh ? m_data[line_of(bus.pc)][int'((bus.pc >> 2) % LW)] : 32'h0);
            chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_refill});
            if (m_refill) chk("mem_addr", bus.mem_addr, m_base + 32'(4 * m_k));
`ifdef ICACHE_STATS_EN
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
`endif
        end
    end

    // ---------------- memory responder ----------------
    int ack_mode = 0;  // 0: ack every cycle, 1: ack every 3rd request cycle
    int wcnt = 0;

    always @(posedge clk) begin
        #1;
        if (ack_mode == 0) begin
            bus.mem_ack = 1'b1;
        end else begin
            if (bus.mem_req) wcnt++;
            bus.mem_ack = (wcnt != 0) && (wcnt % 3 == 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hit(input int maxc, output int n);
        n = 0;
        #2;
        while (bus.ihit !== 1'b1 && n < maxc) begin
            next();
            #2;
            n++;
        end
        if (bus.ihit !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_hit: got no ihit within %0d cycles, required ihit=1", maxc);
        end
    endtask

    initial begin
        int n;
        bus.pc    = 32'h0;
        bus.flush = 1'b0;
        bus.mem_ack = 1'b1;
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        run_chk = 1;
        #1;
        // 1: reset state then zero-wait refill of line 0
        chk("rst_ihit", {31'b0, bus.ihit}, 32'h0);
        chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            next();
            #1;
            chk("t1_req", {31'b0, bus.mem_req}, 32'h1);
            chk("t1_addr", bus.mem_addr, 32'(4 * k));
        end
        next();
        #1;
        chk("t1_ihit", {31'b0, bus.ihit}, 32'h1);
        chk("t1_instr", bus.instr, 32'hA500_0000);
        chk("t1_req_done", {31'b0, bus.mem_req}, 32'h0);

        // 2: same line, word 3
        bus.pc = 32'hC;
        #1;
        chk("t2_ihit", {31'b0, bus.ihit}, 32'h1);
        chk("t2_instr", bus.instr, 32'hA500_000C);
        next();
        #1;
        chk("t2_req", {31'b0, bus.mem_req}, 32'h0);

        // 3: conflict miss on index 0, then the evicted line misses again
        bus.pc = 32'h400;
        #1;
        chk("t3_miss", {31'b0, bus.ihit}, 32'h0);
        next();
        #1;
        chk("t3_addr", bus.mem_addr, 32'h400);
        wait_hit(20, n);
        chk("t3_instr", bus.instr, 32'hA500_0400);
        bus.pc = 32'h0;
        #1;
        chk("t3_evict", {31'b0, bus.ihit}, 32'h0);
        wait_hit(20, n);
        chk("t3_refetch", bus.instr, 32'hA500_0000);

        // 4: slow memory, ack every third cycle
        ack_mode = 1;
        wcnt = 0;
        bus.pc = 32'h800;
        wait_hit(60, n);
        chk("t4_latency", n, 32'd13);
        chk("t4_instr", bus.instr, 32'hA500_0800);

        // 5a: flush during word 2 of a refill
        ack_mode = 0;
        next();
        bus.pc = 32'h1234;
        next();
        #1;
        chk("t5_addr0", bus.mem_addr, 32'h1230);
        next();
        next();
        bus.flush = 1'b1;
        next();
        bus.flush = 1'b0;
        next();
        #1;
        chk("t5_flush_miss", {31'b0, bus.ihit}, 32'h0);
        next();
        #1;
        chk("t5_rerefill", bus.mem_addr, 32'h1230);
        wait_hit(20, n);
        chk("t5_instr", bus.instr, 32'hA500_1234);

        // 5b: flush on the last ack
        next();
        bus.pc = 32'h2000;
        next();
        next();
        next();
        next();
        bus.flush = 1'b1;
        next();
        bus.flush = 1'b0;
        #1;
        chk("t5_flush_last", {31'b0, bus.ihit}, 32'h0);
        wait_hit(20, n);

        // 5c: flush while hitting in idle
        bus.flush = 1'b1;
        #1;
        chk("t5_flush_idle", {31'b0, bus.ihit}, 32'h0);
        next();
        bus.flush = 1'b0;
        wait_hit(20, n);

        // 5d: reset mid-refill
        next();
        bus.pc = 32'h3050;
        next();
        next();
        #1;
        chk("t5_req_mid", {31'b0, bus.mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t5_rst_drop", {31'b0, bus.mem_req}, 32'h0);
        next();
        rst = 1'b0;
        #1;
        chk("t5_rst_inval", {31'b0, bus.ihit}, 32'h0);

        // 6: one miss then three hits since reset
        wait_hit(20, n);
        chk("t6_instr", bus.instr, 32'hA500_3050);
        next();
        next();
        next();
        #1;
`ifdef ICACHE_STATS_EN
        chk("t6_hit_cnt", hit_cnt, 32'd3);
        chk("t6_miss_cnt", miss_cnt, 32'd1);
`endif
        next();
        run_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
